ram_sp_ctrl: RTL and testbench
==============================

Name: ram_sp_ctrl

Overview:
Parametrised single-port synchronous RAM with a select/write access interface and a registered read path with a valid strobe. It has a built-in clear engine that fills the array with INIT_VAL after reset or on request. It also flags out-of-range addresses. It replaces the fixed 1024x8 combinational RAM as the general storage block for datapath and test benches.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 10, address width in bits
DEPTH, 1024, number of implemented words; 1 <= DEPTH <= 2**ADDR_W
INIT_VAL, 0, value written to every word by the clear engine (DATA_W bits)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
sel  in  1  access request, sampled on clk
write  in  1  1 = write access, 0 = read access; qualified by sel
addr  in  ADDR_W  word address
data_in  in  DATA_W  write data
data_out  out  DATA_W  registered read data
rd_valid  out  1  one-cycle strobe: data_out holds a new read result
ready  out  1  1 = accesses accepted; 0 while clearing
clr  in  1  start a clear pass (level sampled in IDLE)
clr_done  out  1  one-cycle pulse on the cycle the clear pass completes
addr_err  out  1  one-cycle pulse: the accepted access had addr >= DEPTH
par_inj  in  1  parity error inject (used only with PARITY_EN)
par_err  out  1  parity mismatch on read (used only with PARITY_EN)

Behaviour:
- Reset (async assert, clocked release): data_out=0, rd_valid=0, ready=0, clr_done=0, addr_err=0, par_err=0, clear counter=0, state=CLEAR.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle, writes INIT_VAL to mem[cnt], then cnt+1.
  - On the cycle that writes cnt=DEPTH-1: next state is IDLE, clr_done pulses that same cycle, cnt returns to 0.
  - One pass takes exactly DEPTH cycles. ready is high from the first IDLE cycle.
- CLEAR, other rules:
  - sel is ignored: no write, no rd_valid, no addr_err.
  - clr is ignored; the pass does not restart.
  - rst mid-pass restarts the pass from address 0.
- IDLE:
  - ready=1.
  - If clr=1, next state is CLEAR and ready drops on the next cycle.
  - If sel and clr are both high in the same cycle, the access completes first and the clear begins on the following cycle.
- Write (sel=1, write=1, ready=1, addr<DEPTH):
  - mem[addr] <= data_in at the edge.
  - data_out and rd_valid are unchanged (rd_valid=0 that cycle).
- Read (sel=1, write=0, ready=1, addr<DEPTH):
  - On the next edge, data_out <= mem[addr] and rd_valid=1 for one cycle.
  - Latency is 1 clock. Back-to-back reads every cycle are supported.
  - data_out holds its value between reads.
- Out of range (addr >= DEPTH, accepted access):
  - A write is dropped.
  - A read returns data_out=0 with rd_valid=1.
  - addr_err pulses in the same cycle as the would-be rd_valid; for writes, one cycle after acceptance.
  - With DEPTH=2**ADDR_W, addr_err never asserts.
- Read after write to the same address on consecutive cycles returns the new data.
- Output widths: data_out is exactly DATA_W; no sign extension anywhere.

Optional Feature:
RAM_PARITY_EN:
- Defined:
  - Each word stores an extra even-parity bit, computed from data_in on write and from INIT_VAL on clear.
  - When par_inj=1 during a write, the stored parity bit is inverted.
  - On a read, par_err=1 together with rd_valid if the recomputed parity does not equal the stored bit; otherwise par_err=0.
  - Out-of-range reads give par_err=0.
- Not defined:
  - No parity storage; par_inj is ignored and par_err is tied 0.
  - Port list is identical in both builds.

Test Plan:
1. Reset, then hold sel=0, with DEPTH=1024 -> ready=0 for 1024 cycles; clr_done pulses once at cycle 1024; ready=1 next cycle; reading addr 5 returns INIT_VAL=0 with rd_valid one cycle later.
2. Write addr k with data k+2 for k=1..16, then read addresses 1..16 back-to-back -> data_out 3..18 on consecutive cycles, rd_valid high for 16 cycles, each value one cycle after its address.
3. Set DEPTH=1000, write 0xAA to addr 1020, then read addr 1020 -> write dropped, addr_err pulses; read gives data_out=0, rd_valid=1, addr_err=1; addr 999 stays unaffected.
4. Write 0x55 to addr 7, pulse clr in the same cycle as a read of addr 7 -> rd_valid shows 0x55; ready=0 next cycle; after 1024 cycles clr_done pulses; reading addr 7 returns 0. A second clr pulse during the pass does not extend it.
5. Assert rst at cycle 300 of the post-reset clear -> outputs return to reset values immediately; after release, ready rises exactly 1024 cycles later.
6. With RAM_PARITY_EN: write 0x0F with par_inj=1 to addr 3 and 0x0F with par_inj=0 to addr 4, then read both -> par_err=1 for addr 3 and 0 for addr 4, both with rd_valid. Without the macro -> par_err=0 in both cases.

Source files
------------

// File: rtl/ram_sp_ctrl.sv
// Single-port synchronous RAM with a registered read path, out-of-range flagging and a clear engine.
// Optional per-word even parity is enabled by defining RAM_PARITY_EN.
`timescale 1ns/1ps
module ram_sp_ctrl #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 10,
    parameter int                DEPTH    = 1024,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              ready,
    input  logic              clr,
    output logic              clr_done,
    output logic              addr_err,
    input  logic              par_inj,
    output logic              par_err
);

    localparam int                MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_AW-1:0] LAST_IDX = MEM_AW'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [MEM_AW-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ready_q, ready_d;
    logic              clr_done_q, clr_done_d;
    logic              addr_err_q, addr_err_d;
    logic              par_err_q, par_err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range_s;
    logic [MEM_AW-1:0] acc_idx_s;
    logic              mem_we_s;
    logic [MEM_AW-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              par_rd_err_s;

    assign in_range_s = ({1'b0, addr} < DEPTH_W);
    assign acc_idx_s  = addr[MEM_AW-1:0];

`ifdef RAM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_wbit_s;

    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Parity bit to store: clear pattern, or write data with optional inversion
    always_comb begin
        par_wbit_s = even_par(INIT_VAL);
        if (state_q == ST_IDLE) begin
            par_wbit_s = even_par(data_in) ^ par_inj;
        end else begin
            par_wbit_s = even_par(INIT_VAL);
        end
    end

    // Parity storage shares the data array write port
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            par_mem[mem_addr_s] <= par_wbit_s;
        end
    end

    assign par_rd_err_s = in_range_s && (even_par(mem[acc_idx_s]) != par_mem[acc_idx_s]);
`else
    logic unused_par_inj_s;
    assign unused_par_inj_s = par_inj;
    assign par_rd_err_s     = 1'b0;
`endif

    // Next-state, clear sequencing and access decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        addr_err_d  = 1'b0;
        par_err_d   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = cnt_q;
        mem_wdata_s = INIT_VAL;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (sel) begin
                    addr_err_d = ~in_range_s;
                    if (write) begin
                        mem_we_s    = in_range_s;
                        mem_addr_s  = acc_idx_s;
                        mem_wdata_s = data_in;
                    end else begin
                        rd_valid_d = 1'b1;
                        data_out_d = in_range_s ? mem[acc_idx_s] : '0;
                        par_err_d  = par_rd_err_s;
                    end
                end else begin
                    addr_err_d = 1'b0;
                end
                // A clear request takes effect after any access in the same cycle
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
        // clr_done is registered so that it is high while the last word is written
        clr_done_d = (state_d == ST_CLEAR) && (cnt_d == LAST_IDX);
        ready_d    = (state_d == ST_IDLE);
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            ready_q    <= 1'b0;
            clr_done_q <= 1'b0;
            addr_err_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            ready_q    <= ready_d;
            clr_done_q <= clr_done_d;
            addr_err_q <= addr_err_d;
            par_err_q  <= par_err_d;
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_addr_s] <= mem_wdata_s;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign ready    = ready_q;
    assign clr_done = clr_done_q;
    assign addr_err = addr_err_q;
    assign par_err  = par_err_q;

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Self-checking bench for ram_sp_ctrl: directed steps, read scoreboard, two depths (1024 and 1000).
`timescale 1ns/1ps
module tb_ram_sp_ctrl;

`ifdef RAM_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, clr, sel, write, par_inj;
    logic [9:0] addr;
    logic [7:0] data_in;

    logic [7:0] d1_data_out, d2_data_out;
    logic       d1_rd_valid, d1_ready, d1_clr_done, d1_addr_err, d1_par_err;
    logic       d2_rd_valid, d2_ready, d2_clr_done, d2_addr_err, d2_par_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] d;
        logic       err;
        logic       par;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ram_sp_ctrl #(.DATA_W(8), .ADDR_W(10), .DEPTH(1024), .INIT_VAL(8'h00)) u_dut1 (
        .clk(clk), .rst(rst), .sel(sel), .write(write), .addr(addr), .data_in(data_in),
        .data_out(d1_data_out), .rd_valid(d1_rd_valid), .ready(d1_ready), .clr(clr),
        .clr_done(d1_clr_done), .addr_err(d1_addr_err), .par_inj(par_inj), .par_err(d1_par_err)
    );

    ram_sp_ctrl #(.DATA_W(8), .ADDR_W(10), .DEPTH(1000), .INIT_VAL(8'h00)) u_dut2 (
        .clk(clk), .rst(rst), .sel(sel), .write(write), .addr(addr), .data_in(data_in),
        .data_out(d2_data_out), .rd_valid(d2_rd_valid), .ready(d2_ready), .clr(clr),
        .clr_done(d2_clr_done), .addr_err(d2_addr_err), .par_inj(par_inj), .par_err(d2_par_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d, input logic inj);
        sel = 1'b1; write = 1'b1; addr = a; data_in = d; par_inj = inj;
        @(negedge clk);
        sel = 1'b0; write = 1'b0; par_inj = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [7:0] d, input logic e, input logic p);
        exp_t x;
        sel = 1'b1; write = 1'b0; addr = a; par_inj = 1'b0;
        x.d = d; x.err = e; x.par = p; x.cyc = cyc;
        sb_q.push_back(x);
        @(negedge clk);
        sel = 1'b0;
    endtask

    // Counts cycles until DUT1 becomes ready; optionally injects a clr pulse mid-pass
    task automatic wait_ready(input string tag, input logic pulse_clr);
        int n = 0;
        int done_cnt = 0;
        int done_at = -1;
        int first_ready = -1;
        while (first_ready < 0 && n < 1100) begin
            @(posedge clk);
            #1;
            n++;
            if (d1_clr_done) begin
                done_cnt++;
                done_at = n;
            end
            if (d1_ready) first_ready = n;
            if (pulse_clr && n == 10) clr = 1'b1;
            if (n == 11) clr = 1'b0;
        end
        chk({tag, "_ready_at"}, first_ready, 1024);
        chk({tag, "_done_at"}, done_at, 1023);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        @(negedge clk);
    endtask

    // Scoreboard: every DUT1 read result must match the oldest pending read, one cycle after issue
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (d1_rd_valid) begin
                if (sb_q.size() == 0) begin
                    chk("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    x = sb_q.pop_front();
                    chk("rd_data", d1_data_out, x.d);
                    chk("rd_latency", cyc, x.cyc + 1);
                    chk("rd_addr_err", d1_addr_err, x.err);
                    chk("rd_par_err", d1_par_err, x.par);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; sel = 1'b0; write = 1'b0; par_inj = 1'b0;
        addr = '0; data_in = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", d1_ready, 1'b0);
        chk("rst_rd_valid", d1_rd_valid, 1'b0);
        chk("rst_data_out", d1_data_out, 8'h00);
        chk("rst_clr_done", d1_clr_done, 1'b0);
        chk("rst_addr_err", d1_addr_err, 1'b0);
        chk("rst_par_err", d1_par_err, 1'b0);
        rst = 1'b0;

        // Post-reset clear, then INIT_VAL readback
        wait_ready("init", 1'b0);
        rd(10'd5, 8'h00, 1'b0, 1'b0);

        // Write k+2 to k, then back-to-back reads
        for (int k = 1; k <= 16; k++) wr(10'(k), 8'(k + 2), 1'b0);
        for (int k = 1; k <= 16; k++) rd(10'(k), 8'(k + 2), 1'b0, 1'b0);

        // Out-of-range access on the 1000-word instance
        wr(10'd999, 8'h33, 1'b0);
        wr(10'd1020, 8'hAA, 1'b0);
        chk("oor_wr_err", d2_addr_err, 1'b1);
        chk("inr_wr_err", d1_addr_err, 1'b0);
        rd(10'd1020, 8'hAA, 1'b0, 1'b0);
        chk("oor_rd_valid", d2_rd_valid, 1'b1);
        chk("oor_rd_data", d2_data_out, 8'h00);
        chk("oor_rd_err", d2_addr_err, 1'b1);
        chk("oor_rd_par", d2_par_err, 1'b0);
        rd(10'd999, 8'h33, 1'b0, 1'b0);
        chk("d999_data", d2_data_out, 8'h33);
        chk("d999_err", d2_addr_err, 1'b0);

        // Read and clr in the same cycle, second clr mid-pass ignored
        wr(10'd7, 8'h55, 1'b0);
        clr = 1'b1;
        rd(10'd7, 8'h55, 1'b0, 1'b0);
        clr = 1'b0;
        chk("clr_ready_drop", d1_ready, 1'b0);
        wait_ready("clr", 1'b1);
        rd(10'd7, 8'h00, 1'b0, 1'b0);

        // Reset while idle and in the middle of a clear pass
        wr(10'd2, 8'h5A, 1'b0);
        rd(10'd2, 8'h5A, 1'b0, 1'b0);
        chk("pre_rst_data", d1_data_out, 8'h5A);
        rst = 1'b1;
        #1;
        chk("async_rst_data", d1_data_out, 8'h00);
        chk("async_rst_ready", d1_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", d1_ready, 1'b0);
        chk("mid_rst_valid", d1_rd_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("restart", 1'b0);

        // Parity inject
        wr(10'd3, 8'h0F, 1'b1);
        wr(10'd4, 8'h0F, 1'b0);
        rd(10'd3, 8'h0F, 1'b0, PAR_ON);
        rd(10'd4, 8'h0F, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
